// File: rtl/ft245_emulator.sv
// ft245_emulator
// Device-side model of an FT245-style USB FIFO chip. The FPGA reads the
// host-to-FPGA RX FIFO with the active-low rd strobe and writes the
// FPGA-to-host TX FIFO with the active-low wr strobe over the shared
// 8-bit data bus. A valid/ready port stands in for the USB host.
//
// Ports:
//   clk, rst         single rising-edge clock, synchronous active-high reset
//   rxf              out, active low: RX byte available to read
//   txe              out, active low: TX byte may be written
//   rd, wr           in, active-low strobes from the FPGA (clk-synchronous)
//   data             inout [7:0], driven only while a read is active
//   host_tx_*        host -> RX FIFO push port (valid/ready)
//   host_rx_*        TX FIFO -> host pop port (valid/ready)
//   err              out, one-cycle pulse on a protocol violation
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. valid must not depend on ready; data is meaningful only
// while valid is high; host_tx_ready is low throughout reset.
module ft245_emulator #(
    parameter int DEPTH    = 16,
    parameter int RXF_HOLD = 2,
    parameter int TXE_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rxf,
    output logic       txe,
    input  logic       rd,
    input  logic       wr,
    inout  wire  [7:0] data,
    input  logic [7:0] host_tx_data,
    input  logic       host_tx_valid,
    output logic       host_tx_ready,
    output logic [7:0] host_rx_data,
    output logic       host_rx_valid,
    input  logic       host_rx_ready,
    output logic       err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int HMAX = (RXF_HOLD > TXE_HOLD) ? RXF_HOLD : TXE_HOLD;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_HOLD} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_HOLD} w_state_t;

    // ------------------------------------------------------------------
    // RX FIFO (host -> FPGA)
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [AW:0]   rx_count;
    logic          rx_push, rx_pop;

    assign host_tx_ready = !rst && (rx_count != FULL_COUNT);
    assign rx_push       = host_tx_valid && host_tx_ready;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= host_tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (FPGA -> host)
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [AW:0]   tx_count;
    logic          tx_push, tx_pop, tx_full;

    assign tx_full       = (tx_count == FULL_COUNT);
    assign host_rx_valid = (tx_count != '0);
    assign host_rx_data  = tx_mem[tx_rp];
    assign tx_pop        = host_rx_valid && host_rx_ready;

    // The byte is taken straight off the bus in the cycle the wr edge is seen.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobe edge detection. Resetting the samples to 0 means a strobe
    // held low through reset never looks like a fresh falling edge.
    // ------------------------------------------------------------------
    logic rd_d, wr_d, rd_fall, wr_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d <= 1'b0;
            wr_d <= 1'b0;
        end else begin
            rd_d <= rd;
            wr_d <= wr;
        end
    end

    assign rd_fall = !rd && rd_d;
    assign wr_fall = !wr && wr_d;

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    r_state_t      r_state, r_next;
    w_state_t      w_state, w_next;
    logic [HW-1:0] r_cnt, w_cnt;
    logic          r_start, rd_err, wr_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        r_start = 1'b0;
        rx_pop  = 1'b0;
        rd_err  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (rd_fall) begin
                    // A read edge while a write owns the bus is a conflict.
                    if (w_state == W_ACTIVE || rx_count == '0) begin
                        rd_err = 1'b1;
                    end else begin
                        r_next  = R_ACTIVE;
                        r_start = 1'b1;
                    end
                end
            end
            R_ACTIVE: begin
                if (rd) begin
                    rx_pop = 1'b1;
                    r_next = R_HOLD;
                end
            end
            R_HOLD: begin
                if (r_cnt == '0) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                         r_cnt <= '0;
        else if (r_state == R_ACTIVE && r_next == R_HOLD) r_cnt <= HW'(RXF_HOLD);
        else if (r_state == R_HOLD && r_cnt != '0)        r_cnt <= r_cnt - 1'b1;
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        tx_push = 1'b0;
        wr_err  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (wr_fall) begin
                    // The bus belongs to the read side if a read is active or
                    // starts in this very cycle.
                    if (r_state == R_ACTIVE || r_start) begin
                        wr_err = 1'b1;
                    end else begin
                        w_next = W_ACTIVE;
                        if (tx_full) wr_err  = 1'b1;
                        else         tx_push = 1'b1;
                    end
                end
            end
            W_ACTIVE: begin
                if (wr) w_next = W_HOLD;
            end
            W_HOLD: begin
                if (w_cnt == '0) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                         w_cnt <= '0;
        else if (w_state == W_ACTIVE && w_next == W_HOLD) w_cnt <= HW'(TXE_HOLD);
        else if (w_state == W_HOLD && w_cnt != '0)        w_cnt <= w_cnt - 1'b1;
    end

    // ------------------------------------------------------------------
    // Output decode (next values of the registered outputs)
    // ------------------------------------------------------------------
    logic rxf_d, txe_d, oe_d, err_d;

    // rxf/txe only drop once the FSM has settled in IDLE for a full cycle,
    // which gives the chip-like inactive gap after each access. rxf uses the
    // registered count, so a push shows on rxf one edge later.
    always_comb begin
        rxf_d = !(r_state == R_IDLE && r_next == R_IDLE && rx_count != '0);
        txe_d = !(w_state == W_IDLE && w_next == W_IDLE && !tx_full);
        oe_d  = (r_next == R_ACTIVE);
        err_d = rd_err || wr_err;
    end

    logic       data_oe;
    logic [7:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxf     <= 1'b1;
            txe     <= 1'b1;
            err     <= 1'b0;
            data_oe <= 1'b0;
            data_q  <= '0;
        end else begin
            rxf     <= rxf_d;
            txe     <= txe_d;
            err     <= err_d;
            data_oe <= oe_d;
            // The head cannot change while a read is active, so capturing it
            // once at the start keeps the bus stable for the whole access.
            if (r_start) data_q <= rx_mem[rx_rp];
        end
    end

    assign data = data_oe ? data_q : 8'bz;

endmodule

// File: tb/tb_ft245_emulator.sv
module tb_ft245_emulator;

    localparam int DEPTH    = 16;
    localparam int RXF_HOLD = 2;
    localparam int TXE_HOLD = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rd = 1'b1, wr = 1'b1;
    logic       rxf, txe, err;
    wire  [7:0] data;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dq = 8'h00;
    logic [7:0] host_tx_data = 8'h00;
    logic       host_tx_valid = 1'b0;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready = 1'b0;

    assign data = tb_oe ? tb_dq : 8'bz;

    ft245_emulator #(.DEPTH(DEPTH), .RXF_HOLD(RXF_HOLD), .TXE_HOLD(TXE_HOLD)) dut (
        .clk(clk), .rst(rst), .rxf(rxf), .txe(txe), .rd(rd), .wr(wr), .data(data),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
        .host_tx_ready(host_tx_ready), .host_rx_data(host_rx_data),
        .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready), .err(err)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] rx_exp_q[$];   // bytes the host has pushed, not yet read by FPGA
    logic [7:0] tx_exp_q[$];   // bytes the FPGA has written, not yet taken by host
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive and sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic host_push(input logic [7:0] b, input logic exp_ready);
        host_tx_data  = b;
        host_tx_valid = 1'b1;
        chk("host_tx_ready", 8'(host_tx_ready), 8'(exp_ready));
        step();
        host_tx_valid = 1'b0;
        if (exp_ready) rx_exp_q.push_back(b);
    endtask

    task automatic wait_rxf_low();
        for (int i = 0; i < 32 && rxf !== 1'b0; i++) step();
        chk("rxf_low_wait", 8'(rxf), 8'd0);
    endtask

    task automatic wait_txe_low();
        for (int i = 0; i < 32 && txe !== 1'b0; i++) step();
        chk("txe_low_wait", 8'(txe), 8'd0);
    endtask

    // FPGA read with rd held low for 'hold' cycles; expects the model head.
    task automatic fpga_read(input int hold);
        logic [7:0] exp;
        exp = rx_exp_q.pop_front();
        wait_rxf_low();
        rd = 1'b0;
        step();
        chk("rd_oe_on", 8'(dut.data_oe), 8'd1);
        chk("rd_data", data, exp);
        chk("rd_rxf_high", 8'(rxf), 8'd1);
        repeat (hold - 1) step();
        chk("rd_data_stable", data, exp);
        rd = 1'b1;
        step();
        chk("rd_oe_off", 8'(dut.data_oe), 8'd0);
        for (int i = 0; i < RXF_HOLD + 1; i++) begin
            step();
            chk("rd_rxf_hold", 8'(rxf), 8'd1);
        end
        step();
        chk("rd_rxf_after", 8'(rxf), 8'(rx_exp_q.size() == 0));
    endtask

    // FPGA write of byte b with wr held low for 'hold' cycles.
    task automatic fpga_write(input logic [7:0] b, input int hold);
        logic full;
        full = (tx_exp_q.size() == DEPTH);
        if (!full) wait_txe_low();
        tb_dq = b;
        tb_oe = 1'b1;
        wr    = 1'b0;
        step();
        if (!full) tx_exp_q.push_back(b);
        chk("wr_err", 8'(err), 8'(full));
        chk("wr_txe_high", 8'(txe), 8'd1);
        chk("wr_host_valid", 8'(host_rx_valid), 8'd1);
        chk("wr_host_head", host_rx_data, tx_exp_q[0]);
        repeat (hold - 1) step();
        chk("wr_err_single", 8'(err), 8'd0);
        wr    = 1'b1;
        tb_oe = 1'b0;
        step();
        chk("wr_txe_rel", 8'(txe), 8'd1);
        for (int i = 0; i < TXE_HOLD + 1; i++) begin
            step();
            chk("wr_txe_hold", 8'(txe), 8'd1);
        end
        step();
        chk("wr_txe_after", 8'(txe), 8'(tx_exp_q.size() == DEPTH));
    endtask

    task automatic host_drain();
        host_rx_ready = 1'b1;
        while (tx_exp_q.size() > 0) begin
            chk("drain_valid", 8'(host_rx_valid), 8'd1);
            chk("drain_data", host_rx_data, tx_exp_q.pop_front());
            step();
        end
        host_rx_ready = 1'b0;
        chk("drain_empty", 8'(host_rx_valid), 8'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_rxf", 8'(rxf), 8'd1);
        chk("rst_txe", 8'(txe), 8'd1);
        chk("rst_oe", 8'(dut.data_oe), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_tx_ready", 8'(host_tx_ready), 8'd0);
        chk("rst_rx_valid", 8'(host_rx_valid), 8'd0);
        rst = 1'b0;
        step();
        chk("post_rst_rxf", 8'(rxf), 8'd1);
        chk("post_rst_txe", 8'(txe), 8'd0);
        chk("post_rst_oe", 8'(dut.data_oe), 8'd0);

        // Single byte host -> FPGA
        host_push(8'h08, 1'b1);
        chk("push_rxf_same", 8'(rxf), 8'd1);
        step();
        chk("push_rxf_next", 8'(rxf), 8'd0);
        fpga_read(2);

        // Single byte FPGA -> host
        fpga_write(8'h5A, 2);
        host_drain();

        // Fill RX to capacity, then one refused push
        for (int i = 0; i < DEPTH; i++) host_push(8'(i), 1'b1);
        host_push(8'hEE, 1'b0);
        chk("full_tx_ready", 8'(host_tx_ready), 8'd0);
        for (int i = 0; i < DEPTH; i++) fpga_read(2);
        chk("after_fill_ready", 8'(host_tx_ready), 8'd1);

        // Randomized batches in both directions
        for (int rep = 0; rep < 3; rep++) begin
            k = $urandom_range(1, DEPTH);
            for (int i = 0; i < k; i++) host_push(8'($urandom_range(0, 255)), 1'b1);
            for (int i = 0; i < k; i++) fpga_read($urandom_range(2, 4));
            k = $urandom_range(1, DEPTH);
            for (int i = 0; i < k; i++) fpga_write(8'($urandom_range(0, 255)), $urandom_range(2, 4));
            host_drain();
        end

        // Read with RX empty
        rd = 1'b0;
        step();
        chk("empty_rd_err", 8'(err), 8'd1);
        chk("empty_rd_oe", 8'(dut.data_oe), 8'd0);
        step();
        chk("empty_rd_err_once", 8'(err), 8'd0);
        chk("empty_rd_rxf", 8'(rxf), 8'd1);
        chk("empty_rd_ready", 8'(host_tx_ready), 8'd1);
        rd = 1'b1;
        step();

        // Write with TX full
        for (int i = 0; i < DEPTH; i++) fpga_write(8'($urandom_range(0, 255)), 2);
        chk("tx_full_txe", 8'(txe), 8'd1);
        fpga_write(8'hC3, 2);
        host_drain();

        // Write strobe during an active read
        host_push(8'hA7, 1'b1);
        wait_rxf_low();
        rd = 1'b0;
        step();
        chk("cf_oe", 8'(dut.data_oe), 8'd1);
        wr = 1'b0;
        step();
        chk("cf_err", 8'(err), 8'd1);
        chk("cf_no_push", 8'(host_rx_valid), 8'd0);
        chk("cf_data", data, 8'hA7);
        step();
        chk("cf_err_once", 8'(err), 8'd0);
        chk("cf_txe_idle", 8'(txe), 8'd0);
        wr = 1'b1;
        rd = 1'b1;
        void'(rx_exp_q.pop_front());
        step();
        chk("cf_oe_off", 8'(dut.data_oe), 8'd0);
        repeat (RXF_HOLD + 3) step();
        chk("cf_rxf_empty", 8'(rxf), 8'd1);
        chk("cf_tx_empty", 8'(host_rx_valid), 8'd0);

        // Reset while a read is active
        host_push(8'h3C, 1'b1);
        wait_rxf_low();
        rd = 1'b0;
        step();
        chk("mr_oe", 8'(dut.data_oe), 8'd1);
        rst = 1'b1;
        step();
        rx_exp_q.delete();
        tx_exp_q.delete();
        chk("mr_oe_rst", 8'(dut.data_oe), 8'd0);
        chk("mr_rxf_rst", 8'(rxf), 8'd1);
        rst = 1'b0;
        repeat (4) step();
        chk("mr_oe_after", 8'(dut.data_oe), 8'd0);
        chk("mr_rxf_after", 8'(rxf), 8'd1);
        chk("mr_err_after", 8'(err), 8'd0);
        chk("mr_ready_after", 8'(host_tx_ready), 8'd1);
        chk("mr_txe_after", 8'(txe), 8'd0);
        rd = 1'b1;
        step();

        // Recovery after reset
        host_push(8'h99, 1'b1);
        fpga_read(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
